// File: rtl/execute_stage_pipe_pkg.sv
// Shared opcodes, state encoding and helpers for the registered execute stage.
// Optional flags: EXEC_ARITH_FLAGS_EN (consumed by the interface, ALU and top).
package exec_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB = 3'd4;
  localparam logic [OP_W-1:0] OP_SLT = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/execute_stage_pipe_if.sv
// Request/response bundle of the execute stage (register-read side in, writeback side out).
// EXEC_ARITH_FLAGS_EN adds out_carry/out_ovf.
interface execute_stage_pipe_if #(
  parameter int DATA_W = 20,
  parameter int TAG_W  = 3
);
  import exec_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_eq;
  logic              out_zero;
`ifdef EXEC_ARITH_FLAGS_EN
  logic              out_carry;
  logic              out_ovf;
`endif

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
`ifdef EXEC_ARITH_FLAGS_EN
    input  out_carry, out_ovf,
`endif
    input  in_ready, out_valid, out_result, out_tag, out_eq, out_zero
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
`ifdef EXEC_ARITH_FLAGS_EN
    output out_carry, out_ovf,
`endif
    output in_ready, out_valid, out_result, out_tag, out_eq, out_zero
  );

endinterface

// File: rtl/execute_stage_pipe_alu.sv
// exec_alu_comb: single-cycle ops (ADD..SLT) plus operand equality.
// EXEC_ARITH_FLAGS_EN adds carry / signed-overflow outputs for ADD and SUB.
module exec_alu_comb
  import exec_pkg::*;
#(
  parameter int DATA_W = 20
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
`ifdef EXEC_ARITH_FLAGS_EN
  output logic              o_carry,
  output logic              o_ovf,
`endif
  output logic [DATA_W-1:0] o_result,
  output logic              o_eq
);

`ifdef EXEC_ARITH_FLAGS_EN
  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_dif;

  // a + ~b + 1: the extra top bit is the no-borrow carry
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    if (i_op == OP_ADD) begin
      o_carry = w_sum[DATA_W];
      o_ovf   = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_sum[DATA_W-1] != i_a[DATA_W-1]);
    end else if (i_op == OP_SUB) begin
      o_carry = w_dif[DATA_W];
      o_ovf   = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_dif[DATA_W-1] != i_a[DATA_W-1]);
    end
  end
`else
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_dif;

  assign w_sum = i_a + i_b;
  assign w_dif = i_a - i_b;
`endif

  assign o_eq = (i_a == i_b);

  always_comb begin
    o_result = i_a;
    case (i_op)
      OP_ADD:  o_result = w_sum[DATA_W-1:0];
      OP_OR:   o_result = i_a | i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_NOT:  o_result = ~i_a;
      OP_SUB:  o_result = w_dif[DATA_W-1:0];
      OP_SLT:  o_result = {{(DATA_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = i_a;  // zero-distance shift passes A through
    endcase
  end

endmodule

// File: rtl/execute_stage_pipe.sv
// Registered execute stage: one-cycle ALU ops, 1 bit/cycle shifts, valid/ready on both sides, flush.
// EXEC_ARITH_FLAGS_EN adds registered out_carry/out_ovf.
module execute_stage_pipe
  import exec_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int TAG_W  = 3
) (
  input logic               clk,
  input logic               rst,
  execute_stage_pipe_if.slave bus
);

  localparam int SHAMT_W = $clog2(DATA_W);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   w_acc_sh;
  logic                r_dir_right;
  logic [TAG_W-1:0]    r_sh_tag;
  logic                r_sh_eq;

  logic                r_vld;
  logic [DATA_W-1:0]   r_res;
  logic [TAG_W-1:0]    r_tag;
  logic                r_eq;
  logic                r_zero;

  logic [DATA_W-1:0]   w_alu_res;
  logic                w_alu_eq;
  logic                w_accept;
  logic                w_acc_shift;
  logic                w_acc_single;
  logic                w_shift_done;

`ifdef EXEC_ARITH_FLAGS_EN
  logic                w_alu_c;
  logic                w_alu_v;
  logic                r_carry;
  logic                r_ovf;
`endif

  exec_alu_comb #(.DATA_W(DATA_W)) u_alu (
    .i_op     (bus.in_op),
    .i_a      (bus.in_a),
    .i_b      (bus.in_b),
`ifdef EXEC_ARITH_FLAGS_EN
    .o_carry  (w_alu_c),
    .o_ovf    (w_alu_v),
`endif
    .o_result (w_alu_res),
    .o_eq     (w_alu_eq)
  );

  assign w_shamt      = bus.in_b[SHAMT_W-1:0];
  assign bus.in_ready = (r_state == ST_IDLE) && (!r_vld || bus.out_ready) && !bus.flush && !rst;
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_acc_shift  = w_accept && is_shift(bus.in_op) && (w_shamt != '0);
  assign w_acc_single = w_accept && !w_acc_shift;
  assign w_shift_done = (r_state == ST_SHIFT) && (r_cnt == SHAMT_W'(1));
  assign w_acc_sh     = r_dir_right ? (r_acc >> 1) : (r_acc << 1);

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_acc_shift)  w_state_nxt = ST_SHIFT;
        ST_SHIFT: if (w_shift_done) w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Shift amounts >= DATA_W just run out the count; zero fill leaves 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_dir_right <= 1'b0;
      r_sh_tag    <= '0;
      r_sh_eq     <= 1'b0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if (w_acc_shift) begin
      r_cnt       <= w_shamt;
      r_acc       <= bus.in_a;
      r_dir_right <= (bus.in_op == OP_SHR);
      r_sh_tag    <= bus.in_tag;
      r_sh_eq     <= w_alu_eq;
    end else if (r_state == ST_SHIFT) begin
      r_cnt <= r_cnt - SHAMT_W'(1);
      r_acc <= w_acc_sh;
    end
  end

  // Output slot: load on accept or shift completion, clear on drain; a shift
  // accept only happens with the slot empty or draining, so completion never collides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_res   <= '0;
      r_tag   <= '0;
      r_eq    <= 1'b0;
      r_zero  <= 1'b0;
`ifdef EXEC_ARITH_FLAGS_EN
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else if (bus.flush) begin
      r_vld <= 1'b0;
    end else if (w_acc_single) begin
      r_vld   <= 1'b1;
      r_res   <= w_alu_res;
      r_tag   <= bus.in_tag;
      r_eq    <= w_alu_eq;
      r_zero  <= (w_alu_res == '0);
`ifdef EXEC_ARITH_FLAGS_EN
      r_carry <= w_alu_c;
      r_ovf   <= w_alu_v;
`endif
    end else if (w_shift_done) begin
      r_vld   <= 1'b1;
      r_res   <= w_acc_sh;
      r_tag   <= r_sh_tag;
      r_eq    <= r_sh_eq;
      r_zero  <= (w_acc_sh == '0);
`ifdef EXEC_ARITH_FLAGS_EN
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else if (bus.out_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign bus.out_valid  = r_vld;
  assign bus.out_result = r_res;
  assign bus.out_tag    = r_tag;
  assign bus.out_eq     = r_eq;
  assign bus.out_zero   = r_zero;
`ifdef EXEC_ARITH_FLAGS_EN
  assign bus.out_carry  = r_carry;
  assign bus.out_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Bench for execute_stage_pipe: vector table, multi-cycle sequences, randomized transaction model.
// Flag checks compile in with EXEC_ARITH_FLAGS_EN.
module tb_execute_stage_pipe;
  import exec_pkg::*;

  localparam int DW = 20;
  localparam int TW = 3;
  localparam int NT = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_pipe_if #(.DATA_W(DW), .TAG_W(TW)) bus();
  execute_stage_pipe #(.DATA_W(DW), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
    logic [DW-1:0] res;
    logic          eq;
    logic          zero;
    logic          c;
    logic          v;
  } vec_t;

  vec_t tbl [NT];
  int   n_vec = 0;
  int   n_err = 0;

  // randomized model state: result slot and remaining shift cycles
  int            m_busy;
  bit            m_pend;
  logic [DW-1:0] m_res, s_res;
  logic [TW-1:0] m_tag, s_tag;
  logic          m_eq, s_eq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  function automatic logic [DW-1:0] ref_res(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s, sa, sb;
    s  = int'(b[4:0]);
    sa = a[DW-1] ? int'(a) - (1 << DW) : int'(a);
    sb = b[DW-1] ? int'(b) - (1 << DW) : int'(b);
    case (op)
      0: return a + b;
      1: return a | b;
      2: return a & b;
      3: return ~a;
      4: return a - b;
      5: return (sa < sb) ? 20'd1 : 20'd0;
      6: return (s >= DW) ? 20'd0 : (a << s);
      default: return (s >= DW) ? 20'd0 : (a >> s);
    endcase
  endfunction

  // Caller is at posedge+1 with the stage idle and out_ready=1.
  task automatic shift_seq(input string nm, input logic [2:0] op, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] exp);
    int s;
    bit ok;
    s  = int'(b[4:0]);
    ok = 1'b1;
    drive(1'b1, op, a, b, 3'd6);
    #1 chk({nm, " accept"}, bus.in_ready, 1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    for (int j = 1; j <= s; j++) begin
      #1 if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    chk({nm, " busy window"}, ok, 1);
    #1 chk({nm, " result"}, {bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready},
           {1'b1, exp, 3'd6, 1'b1});
    tick();
  endtask

  initial begin
    logic          v, rdy;
    logic [2:0]    op;
    logic [DW-1:0] a, b, r;
    logic [TW-1:0] tg;
    bit            ok;

    tbl[0]  = '{OP_ADD, 20'h00001, 20'h00001, 3'd5, 20'h00002, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{OP_OR,  20'hFFC00, 20'h00003, 3'd1, 20'hFFC03, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{OP_AND, 20'h00205, 20'h0000F, 3'd2, 20'h00005, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{OP_NOT, 20'hFFC00, 20'h12345, 3'd3, 20'h003FF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{OP_SUB, 20'h80000, 20'h00001, 3'd4, 20'h7FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{OP_SUB, 20'h00000, 20'h00001, 3'd6, 20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{OP_SLT, 20'h80000, 20'h00001, 3'd7, 20'h00001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{OP_SLT, 20'h00001, 20'h80000, 3'd0, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{OP_SLT, 20'h12345, 20'h12345, 3'd1, 20'h00000, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{OP_ADD, 20'hFFFFF, 20'h00001, 3'd2, 20'h00000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{OP_SHL, 20'h12345, 20'h00020, 3'd3, 20'h12345, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{OP_SUB, 20'h00005, 20'h00005, 3'd4, 20'h00000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{OP_ADD, 20'h7FFFF, 20'h00001, 3'd5, 20'h80000, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, OP_ADD, 20'h1, 20'h1, 3'd1);

    // reset state
    #12;
    chk("reset in_ready", bus.in_ready, 0);
    chk("reset outputs", {bus.out_valid, bus.out_result, bus.out_tag, bus.out_eq, bus.out_zero}, 0);
    drive(1'b0, OP_ADD, '0, '0, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("in_ready after reset", bus.in_ready, 1);
    tick();

    // back-to-back table: result i appears the cycle after its accept
    for (int i = 0; i <= NT; i++) begin
      if (i < NT) drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
      else        drive(1'b0, OP_ADD, '0, '0, '0);
      #1;
      if (i < NT) chk($sformatf("tbl%0d in_ready", i), bus.in_ready, 1);
      if (i > 0) begin
        chk($sformatf("tbl%0d out", i-1),
            {bus.out_valid, bus.out_result, bus.out_tag, bus.out_eq, bus.out_zero},
            {1'b1, tbl[i-1].res, tbl[i-1].tag, tbl[i-1].eq, tbl[i-1].zero});
`ifdef EXEC_ARITH_FLAGS_EN
        chk($sformatf("tbl%0d flags", i-1), {bus.out_carry, bus.out_ovf}, {tbl[i-1].c, tbl[i-1].v});
`endif
      end
      tick();
    end
    #1 chk("drained", bus.out_valid, 0);
    tick();

    shift_seq("shl4",  OP_SHL, 20'h00001, 20'd4,  20'h00010);
    shift_seq("shr19", OP_SHR, 20'h80000, 20'd19, 20'h00001);
    shift_seq("shl25", OP_SHL, 20'hFFFFF, 20'd25, 20'h00000);
    tick();

    // hold under back-pressure, then drain+accept in one cycle
    bus.out_ready = 1'b0;
    drive(1'b1, OP_NOT, 20'hFFC00, 20'h0, 3'd2);
    #1 chk("hold accept", bus.in_ready, 1);
    tick();
    drive(1'b1, OP_ADD, 20'h2, 20'h3, 3'd5);
    ok = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1 if (bus.out_valid !== 1'b1 || bus.out_result !== 20'h003FF || bus.out_tag !== 3'd2 ||
             bus.in_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    chk("hold stable", ok, 1);
    bus.out_ready = 1'b1;
    #1 chk("release in_ready", {bus.in_ready, bus.out_result}, {1'b1, 20'h003FF});
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    #1 chk("replace result", {bus.out_valid, bus.out_result, bus.out_tag}, {1'b1, 20'h00005, 3'd5});
    tick();
    #1 chk("after replace", bus.out_valid, 0);

    // flush mid-shift
    drive(1'b1, OP_SHL, 20'h1, 20'd10, 3'd1);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    tick();
    tick();
    bus.flush = 1'b1;
    drive(1'b1, OP_ADD, 20'h7, 20'h7, 3'd3);
    #1 chk("flush in_ready", bus.in_ready, 0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, OP_ADD, '0, '0, '0);
    #1 chk("post-flush", {bus.in_ready, bus.out_valid}, {1'b1, 1'b0});
    ok = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("flush no result", ok, 1);

    // flush drops a held result
    bus.out_ready = 1'b0;
    drive(1'b1, OP_ADD, 20'h1, 20'h2, 3'd4);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    bus.flush = 1'b1;
    #1 chk("pending before flush", {bus.out_valid, bus.out_result}, {1'b1, 20'h00003});
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    #1 chk("flush drops pending", bus.out_valid, 0);
    tick();

    // reset mid-shift
    drive(1'b1, OP_SHL, 20'h3, 20'd10, 3'd7);
    tick();
    drive(1'b0, OP_ADD, '0, '0, '0);
    tick();
    tick();
    rst = 1'b1;
    #1 chk("reset mid-shift", {bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag, bus.out_zero}, 0);
    tick();
    tick();
    rst = 1'b0;
    #1 chk("reset release", bus.in_ready, 1);
    ok = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (bus.out_valid !== 1'b0) ok = 1'b0;
    end
    chk("reset no result", ok, 1);

    // randomized traffic against the transaction model
    m_busy = 0;
    m_pend = 1'b0;
    m_res = '0; m_tag = '0; m_eq = 1'b0;
    s_res = '0; s_tag = '0; s_eq = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      tick();
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      a  = DW'($urandom);
      b  = ($urandom_range(0, 4) == 0) ? a : DW'($urandom);
      if (op >= 3'd6 && $urandom_range(0, 1) == 1) b = DW'($urandom_range(0, 5));
      tg = TW'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive(v, op, a, b, tg);
      #1;
      rdy = (m_busy == 0) && (!m_pend || bus.out_ready);
      chk("rand in_ready", bus.in_ready, rdy);
      chk("rand out_valid", bus.out_valid, m_pend);
      if (m_pend)
        chk("rand out", {bus.out_result, bus.out_tag, bus.out_eq, bus.out_zero},
            {m_res, m_tag, m_eq, (m_res == '0)});
      if (m_pend && bus.out_ready) m_pend = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_pend = 1'b1; m_res = s_res; m_tag = s_tag; m_eq = s_eq;
        end
      end
      if (v && rdy) begin
        r = ref_res(int'(op), a, b);
        if (op >= 3'd6 && b[4:0] != 5'd0) begin
          m_busy = int'(b[4:0]); s_res = r; s_tag = tg; s_eq = (a == b);
        end else begin
          m_pend = 1'b1; m_res = r; m_tag = tg; m_eq = (a == b);
        end
      end
    end

    drive(1'b0, OP_ADD, '0, '0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
